// File: rtl/sample_packer.sv
// Collects DWIDTH-bit samples into NUM_INPUTS-slot frames for a downstream adder tree.
// Optional macro SAMPLE_PACKER_DOUBLE_BUF_EN adds a waiting stage so collection overlaps presentation.
module sample_packer #(
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned DWIDTH     = 14,
  localparam int unsigned CW        = $clog2(NUM_INPUTS + 1),
  localparam int unsigned VW        = NUM_INPUTS * DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic              i_flush,
  output logic [VW-1:0]     o_dat_vector,
  output logic [CW-1:0]     o_cnt,
  output logic              o_vld,
  input  logic              i_rdy
);

  localparam int unsigned IW = $clog2(NUM_INPUTS);

  logic [VW-1:0] col_q, col_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [VW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;

  logic          acc_c;
  logic          flush_c;
  logic          last_c;
  logic          done_c;
  logic [VW-1:0] frame_c;
  logic [CW-1:0] frame_cnt_c;

`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
  logic          pend_q, pend_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic          out_free_c;

  // Stall only while a finished frame is parked behind an occupied output.
  assign o_rdy      = ~rst & ~(pend_q & vld_q);
  assign out_free_c = ~vld_q | i_rdy;
`else
  assign o_rdy = ~vld_q & ~rst;
`endif

  assign acc_c       = i_vld & o_rdy;
  assign flush_c     = i_flush & o_rdy;
  assign last_c      = (wr_idx_q == IW'(NUM_INPUTS - 1));
  assign frame_cnt_c = CW'(wr_idx_q) + CW'(acc_c);
  assign done_c      = (acc_c & last_c) | (flush_c & ((wr_idx_q != '0) | acc_c));

  // Collect buffer with this cycle's accepted sample merged in.
  always_comb begin
    frame_c = col_q;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (acc_c && (wr_idx_q == IW'(k))) begin
        frame_c[DWIDTH*k +: DWIDTH] = i_dat;
      end
    end
  end

  always_comb begin
    col_d    = col_q;
    wr_idx_d = wr_idx_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
`endif

    if (vld_q && i_rdy) begin
      vld_d = 1'b0;
    end

    if (acc_c) begin
      col_d    = frame_c;
      wr_idx_d = last_c ? '0 : wr_idx_q + IW'(1);
    end

`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
    if (pend_q && out_free_c) begin
      out_d  = col_q;
      cnt_d  = pend_cnt_q;
      vld_d  = 1'b1;
      col_d  = '0;
      pend_d = 1'b0;
    end

    if (done_c) begin
      wr_idx_d = '0;
      if (out_free_c) begin
        out_d = frame_c;
        cnt_d = frame_cnt_c;
        vld_d = 1'b1;
        col_d = '0;
      end else begin
        col_d      = frame_c;
        pend_d     = 1'b1;
        pend_cnt_d = frame_cnt_c;
      end
    end
`else
    if (done_c) begin
      out_d    = frame_c;
      cnt_d    = frame_cnt_c;
      vld_d    = 1'b1;
      col_d    = '0;
      wr_idx_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      wr_idx_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
      pend_q     <= 1'b0;
      pend_cnt_q <= '0;
`endif
    end else begin
      col_q    <= col_d;
      wr_idx_q <= wr_idx_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
`endif
    end
  end

  assign o_dat_vector = out_q;
  assign o_cnt        = cnt_q;
  assign o_vld        = vld_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed and random checks of sample_packer against a frame scoreboard.
// Honours SAMPLE_PACKER_DOUBLE_BUF_EN for the buffering-dependent expectations.
module tb_sample_packer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 14;
  localparam int unsigned CW = 5;
  localparam int unsigned VW = N * DW;

  typedef struct packed {
    logic [VW-1:0] vec;
    logic [CW-1:0] cnt;
  } frame_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_dat;
  logic          i_vld;
  logic          o_rdy;
  logic          i_flush;
  logic [VW-1:0] o_dat_vector;
  logic [CW-1:0] o_cnt;
  logic          o_vld;
  logic          i_rdy;

  sample_packer #(.NUM_INPUTS(N), .DWIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_dat        (i_dat),
    .i_vld        (i_vld),
    .o_rdy        (o_rdy),
    .i_flush      (i_flush),
    .o_dat_vector (o_dat_vector),
    .o_cnt        (o_cnt),
    .o_vld        (o_vld),
    .i_rdy        (i_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  frame_t        exp_q[$];
  logic [VW-1:0] cur_vec;
  int            cur_cnt;
  logic          hold_pend;
  logic [VW-1:0] hold_dat;
  logic [CW-1:0] hold_cnt;
  logic          last_acc;
  logic          last_rdy;
  int            frames_out;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Mid-cycle observer: output handshake, hold stability, and the input-side reference model.
  task automatic monitor();
    logic   acc;
    logic   fl;
    frame_t f;
    if (rst) begin
      exp_q.delete();
      cur_vec   = '0;
      cur_cnt   = 0;
      hold_pend = 1'b0;
      last_acc  = 1'b0;
      last_rdy  = 1'b0;
      return;
    end
    if (hold_pend) begin
      chk("hold_vld", VW'(o_vld), VW'(1));
      chk("hold_dat", o_dat_vector, hold_dat);
      chk("hold_cnt", VW'(o_cnt), VW'(hold_cnt));
    end
    if (o_vld === 1'b1 && i_rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_frame", VW'(o_vld), VW'(0));
      end else begin
        f = exp_q.pop_front();
        chk("frame_dat", o_dat_vector, f.vec);
        chk("frame_cnt", VW'(o_cnt), VW'(f.cnt));
        frames_out++;
      end
    end
    hold_pend = (o_vld === 1'b1) && !i_rdy;
    hold_dat  = o_dat_vector;
    hold_cnt  = o_cnt;
    acc       = i_vld && (o_rdy === 1'b1);
    fl        = i_flush && (o_rdy === 1'b1);
    last_acc  = acc;
    last_rdy  = (o_rdy === 1'b1);
    if (acc) begin
      cur_vec[DW*cur_cnt +: DW] = i_dat;
      cur_cnt++;
    end
    if (cur_cnt == int'(N) || (fl && cur_cnt != 0)) begin
      f.vec = cur_vec;
      f.cnt = CW'(cur_cnt);
      exp_q.push_back(f);
      cur_vec = '0;
      cur_cnt = 0;
    end
  endtask

  task automatic cyc(input logic vld, input logic [DW-1:0] dat, input logic flush, input logic rdy);
    i_vld   = vld;
    i_dat   = dat;
    i_flush = flush;
    i_rdy   = rdy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] ev;
  logic [DW-1:0] seq;
  logic [DW-1:0] r_dat;
  logic          fl_hold;
  int            sum;
  int            nacc;
  int            target;

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_dat = '0; i_flush = 1'b0; i_rdy = 1'b0;
    cur_vec = '0; cur_cnt = 0; hold_pend = 1'b0; hold_dat = '0; hold_cnt = '0;
    last_acc = 1'b0; last_rdy = 1'b0; frames_out = 0;
    #1;
    chk("rst_rdy_t0", VW'(o_rdy), VW'(0));
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_vld", VW'(o_vld), VW'(0));
    chk("rst_cnt", VW'(o_cnt), VW'(0));
    chk("rst_dat", o_dat_vector, VW'(0));
    chk("rst_rdy", VW'(o_rdy), VW'(0));
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", VW'(o_rdy), VW'(1));

    // Full frame 1..16.
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(k + 1), 1'b0, 1'b1);
    ev = '0;
    for (int k = 0; k < 16; k++) ev[DW*k +: DW] = DW'(k + 1);
    chk("t1_vld", VW'(o_vld), VW'(1));
    chk("t1_cnt", VW'(o_cnt), VW'(16));
    chk("t1_dat", o_dat_vector, ev);
    sum = 0;
    for (int k = 0; k < 16; k++) sum += int'(o_dat_vector[DW*k +: DW]);
    chk("t1_sum", VW'(sum), VW'(136));
`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
    chk("t1_rdy", VW'(o_rdy), VW'(1));
`else
    chk("t1_rdy", VW'(o_rdy), VW'(0));
`endif
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t1_drained", VW'(o_vld), VW'(0));

    // Partial frame of five 0x3FF then flush.
    for (int k = 0; k < 5; k++) cyc(1'b1, DW'(14'h3FF), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    ev = '0;
    for (int k = 0; k < 5; k++) ev[DW*k +: DW] = DW'(14'h3FF);
    chk("t2_vld", VW'(o_vld), VW'(1));
    chk("t2_cnt", VW'(o_cnt), VW'(5));
    chk("t2_dat", o_dat_vector, ev);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: frame presented, downstream stalls 20 cycles with input streaming.
    seq = DW'(14'h200);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, seq, 1'b0, 1'b1);
      if (last_acc) seq = seq + DW'(1);
    end
    nacc = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, seq, 1'b0, 1'b0);
      if (last_acc) begin
        seq = seq + DW'(1);
        nacc++;
      end
    end
`ifdef SAMPLE_PACKER_DOUBLE_BUF_EN
    chk("t3_accepts", VW'(nacc), VW'(16));
`else
    chk("t3_accepts", VW'(nacc), VW'(0));
`endif
    chk("t3_rdy_stalled", VW'(o_rdy), VW'(0));
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_queue_empty", VW'(exp_q.size()), VW'(0));
    chk("t3_vld_idle", VW'(o_vld), VW'(0));

    // Flush with nothing collected, then flush together with the 16th accept.
    cyc(1'b0, '0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t4_empty_flush", VW'(o_vld), VW'(0));
    for (int k = 0; k < 15; k++) cyc(1'b1, DW'(k + 40), 1'b0, 1'b1);
    cyc(1'b1, DW'(55), 1'b1, 1'b1);
    chk("t4_vld", VW'(o_vld), VW'(1));
    chk("t4_cnt", VW'(o_cnt), VW'(16));
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t4_no_extra", VW'(o_vld), VW'(0));

    // Reset mid-frame, then a clean frame of 0x100.
    for (int k = 0; k < 7; k++) cyc(1'b1, DW'(k + 7), 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_rdy_in_rst", VW'(o_rdy), VW'(0));
    rst = 1'b0;
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(14'h100), 1'b0, 1'b1);
    ev = '0;
    for (int k = 0; k < 16; k++) ev[DW*k +: DW] = DW'(14'h100);
    chk("t5_vld", VW'(o_vld), VW'(1));
    chk("t5_cnt", VW'(o_cnt), VW'(16));
    chk("t5_dat", o_dat_vector, ev);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t5_queue_empty", VW'(exp_q.size()), VW'(0));

    // Random traffic with gaps and occasional held flushes.
    target  = frames_out + 40;
    r_dat   = DW'($urandom & 32'h3FF);
    fl_hold = 1'b0;
    for (int c = 0; c < 8000 && frames_out < target; c++) begin
      if (!fl_hold) fl_hold = ($urandom_range(0, 19) == 0);
      cyc(($urandom_range(0, 9) < 7), r_dat, fl_hold, ($urandom_range(0, 9) < 7));
      if (last_acc) r_dat = DW'($urandom & 32'h3FF);
      if (fl_hold && last_rdy) fl_hold = 1'b0;
    end
    chk("rand_frames_reached", VW'(frames_out >= target), VW'(1));
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      if (last_rdy) break;
    end
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("rand_queue_empty", VW'(exp_q.size()), VW'(0));
    chk("rand_vld_idle", VW'(o_vld), VW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter NUM_INPUTS, default 16, number of sample slots per frame (>=2).
REQ-002 Parameter DWIDTH, default 14, width of one sample.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_dat  input  DWIDTH  incoming sample.
REQ-006 i_vld  input  1  i_dat valid.
REQ-007 o_rdy  output  1  packer can accept i_dat this cycle.
REQ-008 i_flush  input  1  request to emit a partially filled frame.
REQ-009 o_dat_vector  output  NUM_INPUTS*DWIDTH  packed frame; slot k at bits [DWIDTH*k +: DWIDTH].
REQ-010 o_cnt  output  CW = ceil(log2(NUM_INPUTS+1))  number of filled slots in the emitted frame.
REQ-011 o_vld  output  1  o_dat_vector/o_cnt valid.
REQ-012 i_rdy  input  1  downstream (adder tree stage) accepts the frame.

Function
REQ-013 Input accept = i_vld & o_rdy at a rising edge; accepted sample written to slot wr_idx, then wr_idx increments.
REQ-014 Slot order: first accepted sample of a frame lands in slot 0 (LSBs), the last in slot NUM_INPUTS-1.
REQ-015 Accept into slot NUM_INPUTS-1 completes the frame; wr_idx wraps to 0 on that edge.
REQ-016 Frame completed at edge k, output register free -> o_vld=1, o_cnt=NUM_INPUTS, frame on o_dat_vector after edge k (one-cycle latency from last accept).
REQ-017 Output handshake = o_vld & i_rdy at a rising edge; o_vld clears after that edge unless a new frame loads on the same edge.
REQ-018 While o_vld=1 and i_rdy=0, o_dat_vector and o_cnt hold stable.
REQ-019 i_flush acted on only in a cycle with o_rdy=1; upstream holds it until then.
REQ-020 Flush with wr_idx>0: frame emitted with o_cnt=wr_idx (plus 1 if a sample is accepted the same cycle; that sample is included); unfilled slots read zero; wr_idx returns to 0.
REQ-021 Flush with wr_idx=0 and no sample accepted: ignored, no frame emitted.
REQ-022 Flush on the same edge as an accept into slot NUM_INPUTS-1: one full frame, o_cnt=NUM_INPUTS, no extra empty frame.
REQ-023 After any emitted frame, collection slots restart from zero content.
REQ-024 No sample is dropped or duplicated; o_rdy is the sole backpressure mechanism.

Reset
REQ-025 rst high at a rising edge: o_vld=0, o_cnt=0, o_dat_vector=0, wr_idx=0, any pending frame discarded.
REQ-026 o_rdy=0 in every cycle rst is high; o_rdy=1 in the first cycle after rst deasserts.
REQ-027 Reset mid-frame discards partial samples; next accepted sample goes to slot 0.

Configuration
REQ-028 Macro SAMPLE_PACKER_DOUBLE_BUF_EN selects buffering.
REQ-029 Defined: separate collect buffer and output register; o_rdy=0 only when a completed/flushed frame waits in the collect buffer and the output register is still occupied; waiting frame moves to output on the edge the occupied frame hands off; sustained i_vld=1, i_rdy=1 gives one frame per NUM_INPUTS cycles with no stall.
REQ-030 Not defined: single buffer; o_rdy = ~o_vld & ~rst; collection pauses while a frame is presented; sustained throughput one frame per NUM_INPUTS+1 cycles.

Verification
REQ-031 Reset, then 16 samples 1..16 with i_vld=1, i_rdy=1 -> o_vld one cycle after 16th accept, slot k = k+1, o_cnt=16; adder_tree downstream sums to 136.
REQ-032 5 samples 0x3FF then i_flush=1 -> o_cnt=5, slots 0-4 = 0x3FF, slots 5-15 = 0.
REQ-033 Full frame presented, i_rdy=0 for 20 cycles, i_vld=1 throughout -> o_dat_vector stable; o_rdy drops (immediately without macro, after 16 more accepts with macro); no sample lost once i_rdy=1.
REQ-034 i_flush with wr_idx=0 -> no o_vld; i_flush together with 16th accept -> exactly one frame, o_cnt=16.
REQ-035 rst asserted after 7 accepts, then 16 samples 0x100 -> single frame all slots 0x100, o_cnt=16.
REQ-036 40 random frames (samples & 0x3FF), random i_vld/i_rdy gaps, both macro settings -> emitted frames match a reference queue in order.
